// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, HID keycodes, key decoder.
package connect4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int MAX_MOVES = NUM_COLS * NUM_ROWS;

    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] KEY_BACK   = 8'h05;
    localparam logic [7:0] KEY_RED_C1 = 8'h1E;
    localparam logic [7:0] KEY_RED_C2 = 8'h1F;
    localparam logic [7:0] KEY_RED_C3 = 8'h20;
    localparam logic [7:0] KEY_RED_C4 = 8'h21;
    localparam logic [7:0] KEY_RED_C5 = 8'h22;
    localparam logic [7:0] KEY_RED_C6 = 8'h23;
    localparam logic [7:0] KEY_RED_C7 = 8'h24;
    localparam logic [7:0] KEY_BLK_C1 = 8'h14;
    localparam logic [7:0] KEY_BLK_C2 = 8'h1A;
    localparam logic [7:0] KEY_BLK_C3 = 8'h08;
    localparam logic [7:0] KEY_BLK_C4 = 8'h15;
    localparam logic [7:0] KEY_BLK_C5 = 8'h17;
    localparam logic [7:0] KEY_BLK_C6 = 8'h1C;
    localparam logic [7:0] KEY_BLK_C7 = 8'h18;

    typedef enum logic {
        ST_ARMED        = 1'b0,
        ST_WAIT_RELEASE = 1'b1
    } gate_state_t;

    typedef struct packed {
        logic       valid;
        logic       is_back;
        logic       is_red;
        logic [2:0] col_idx;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [7:0] kc);
        key_dec_t d;
        d = '0;
        if (kc >= KEY_RED_C1 && kc <= KEY_RED_C7) begin
            d.valid   = 1'b1;
            d.is_red  = 1'b1;
            d.col_idx = 3'(kc - KEY_RED_C1);
        end else begin
            case (kc)
                KEY_BLK_C1: d = '{1'b1, 1'b0, 1'b0, 3'd0};
                KEY_BLK_C2: d = '{1'b1, 1'b0, 1'b0, 3'd1};
                KEY_BLK_C3: d = '{1'b1, 1'b0, 1'b0, 3'd2};
                KEY_BLK_C4: d = '{1'b1, 1'b0, 1'b0, 3'd3};
                KEY_BLK_C5: d = '{1'b1, 1'b0, 1'b0, 3'd4};
                KEY_BLK_C6: d = '{1'b1, 1'b0, 1'b0, 3'd5};
                KEY_BLK_C7: d = '{1'b1, 1'b0, 1'b0, 3'd6};
                KEY_BACK:   d = '{1'b1, 1'b1, 1'b0, 3'd0};
                default:    d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/drop_cmd_ctrl_key_release_gate.sv
// One strobe per key press: after a press, keycode must read zero for
// RELEASE_FRAMES consecutive frames before the next press is accepted.
//
// state           | meaning
// ST_ARMED        | ready; a recognised key fires press this frame
// ST_WAIT_RELEASE | counting consecutive zero-keycode frames
module key_release_gate
    import connect4_pkg::*;
#(
    parameter int RELEASE_FRAMES = 2
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic key_zero,
    input  logic key_valid,
    output logic press
);

    localparam int CNT_W = $clog2(RELEASE_FRAMES + 1);

    gate_state_t      state_q, state_d;
    logic [CNT_W-1:0] rel_cnt_q, rel_cnt_d;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_ARMED;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            ST_ARMED: begin
                rel_cnt_d = '0;
                if (key_valid) state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!key_zero) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == CNT_W'(RELEASE_FRAMES - 1)) begin
                    state_d   = ST_ARMED;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_ARMED;
                rel_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        press = (state_q == ST_ARMED) && key_valid;
    end

endmodule

// File: rtl/drop_cmd_ctrl.sv
// Keycode to one-hot drop commands with turn tracking and move counting.
// Optional DROP_CMD_STRICT_TURN_EN: off-turn column keys are rejected.
module drop_cmd_ctrl
    import connect4_pkg::*;
#(
    parameter int RELEASE_FRAMES = 2
) (
    input  logic                frame_clk,
    input  logic                Reset,
    input  logic [7:0]          keycode,
    input  logic [NUM_COLS-1:0] col_full,
    output logic [NUM_COLS-1:0] drop_col_red,
    output logic [NUM_COLS-1:0] drop_col_black,
    output logic                turn_red,
    output logic                invalid,
    output logic                back,
    output logic [5:0]          move_count,
    output logic                board_full
);

    key_dec_t dec;
    logic     press;

    logic [NUM_COLS-1:0] drop_red_q, drop_red_d;
    logic [NUM_COLS-1:0] drop_blk_q, drop_blk_d;
    logic                turn_red_q, turn_red_d;
    logic                invalid_q, invalid_d;
    logic                back_q, back_d;
    logic [5:0]          move_count_q, move_count_d;
    logic                board_full_q, board_full_d;
    logic                turn_ok;
    logic [NUM_COLS-1:0] col_onehot;

    always_comb dec = decode_key(keycode);

    key_release_gate #(
        .RELEASE_FRAMES(RELEASE_FRAMES)
    ) u_gate (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .key_zero  (keycode == KEY_NONE),
        .key_valid (dec.valid),
        .press     (press)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            drop_red_q   <= '0;
            drop_blk_q   <= '0;
            turn_red_q   <= 1'b1;
            invalid_q    <= 1'b0;
            back_q       <= 1'b0;
            move_count_q <= '0;
            board_full_q <= 1'b0;
        end else begin
            drop_red_q   <= drop_red_d;
            drop_blk_q   <= drop_blk_d;
            turn_red_q   <= turn_red_d;
            invalid_q    <= invalid_d;
            back_q       <= back_d;
            move_count_q <= move_count_d;
            board_full_q <= board_full_d;
        end
    end

    always_comb begin
        drop_red_d   = '0;
        drop_blk_d   = '0;
        invalid_d    = 1'b0;
        back_d       = 1'b0;
        turn_red_d   = turn_red_q;
        move_count_d = move_count_q;
        board_full_d = board_full_q;
        col_onehot   = NUM_COLS'(1) << dec.col_idx;
`ifdef DROP_CMD_STRICT_TURN_EN
        turn_ok      = (dec.is_red == turn_red_q);
`else
        turn_ok      = 1'b1;
`endif
        if (press) begin
            if (dec.is_back) begin
                back_d = 1'b1;
            end else if (col_full[dec.col_idx] || board_full_q || !turn_ok) begin
                invalid_d = 1'b1;
            end else begin
                if (dec.is_red) drop_red_d = col_onehot;
                else            drop_blk_d = col_onehot;
                turn_red_d = ~turn_red_q;
                // board_full already blocks drops; the guard keeps the count from wrapping regardless
                if (move_count_q != 6'(MAX_MOVES)) move_count_d = move_count_q + 6'd1;
                board_full_d = (move_count_d == 6'(MAX_MOVES));
            end
        end
    end

    assign drop_col_red   = drop_red_q;
    assign drop_col_black = drop_blk_q;
    assign turn_red       = turn_red_q;
    assign invalid        = invalid_q;
    assign back           = back_q;
    assign move_count     = move_count_q;
    assign board_full     = board_full_q;

endmodule

// File: tb/tb_drop_cmd_ctrl.sv
// Scoreboard bench for drop_cmd_ctrl: a behavioural model pushes the expected
// output vector per frame, each test task pops and compares after the edge.
module tb_drop_cmd_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [6:0] col_full;
    logic [6:0] drop_col_red, drop_col_black;
    logic       turn_red, invalid, back, board_full;
    logic [5:0] move_count;

    drop_cmd_ctrl #(.RELEASE_FRAMES(2)) dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .col_full       (col_full),
        .drop_col_red   (drop_col_red),
        .drop_col_black (drop_col_black),
        .turn_red       (turn_red),
        .invalid        (invalid),
        .back           (back),
        .move_count     (move_count),
        .board_full     (board_full)
    );

    always #5 frame_clk = ~frame_clk;

    logic [23:0] dut_vec;
    assign dut_vec = {drop_col_red, drop_col_black, turn_red, invalid, back, move_count, board_full};

    localparam logic [23:0] RESET_VEC = {7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0};

    int passed = 0;
    int total  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_v;

    logic [7:0] blk_keys [7] = '{8'h14, 8'h1A, 8'h08, 8'h15, 8'h17, 8'h1C, 8'h18};

    bit m_armed;
    int m_cnt;
    bit m_turn;
    int m_count;
    bit m_full;

    task automatic model_reset();
        m_armed = 1; m_cnt = 0; m_turn = 1; m_count = 0; m_full = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [7:0] key);
        logic [6:0] r, b;
        logic inv, bk;
        bit rec, is_red, is_back;
        int col;
        r = '0; b = '0; inv = 0; bk = 0;
        rec = 0; is_red = 0; is_back = 0; col = 0;
        for (int i = 0; i < 7; i++) begin
            if (key == 8'h1E + 8'(i)) begin rec = 1; is_red = 1; col = i; end
            if (key == blk_keys[i])   begin rec = 1; is_red = 0; col = i; end
        end
        if (key == 8'h05) begin rec = 1; is_back = 1; end
        if (m_armed) begin
            if (rec) begin
                m_armed = 0;
                m_cnt = 0;
                if (is_back) bk = 1;
`ifdef DROP_CMD_STRICT_TURN_EN
                else if (col_full[col] || m_full || (is_red != m_turn)) inv = 1;
`else
                else if (col_full[col] || m_full) inv = 1;
`endif
                else begin
                    if (is_red) r[col] = 1'b1; else b[col] = 1'b1;
                    m_turn = !m_turn;
                    m_count++;
                    if (m_count == 42) m_full = 1;
                end
            end
        end else if (key == 8'h00) begin
            m_cnt++;
            if (m_cnt == 2) begin m_armed = 1; m_cnt = 0; end
        end else begin
            m_cnt = 0;
        end
        exp_q.push_back({r, b, m_turn, inv, bk, 6'(m_count), m_full});
    endtask

    task automatic frame(input logic [7:0] key);
        keycode = key;
        model_edge(key);
        @(posedge frame_clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1; keycode = 8'h00; col_full = '0;
        model_reset();
        #2;
        total++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset: got %h want %h", dut_vec, RESET_VEC);
        else passed++;
        #1 Reset = 0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            frame(8'h24);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL hold[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
            if (i == 0) begin
                total++;
                if (drop_col_red !== 7'b1000000) $display("FAIL hold_first_drop: got %b want 1000000", drop_col_red);
                else passed++;
            end
        end
        total++;
        if (turn_red !== 1'b0 || move_count !== 6'd1) $display("FAIL hold_state: got turn %b cnt %0d want 0 1", turn_red, move_count);
        else passed++;
    endtask

    task automatic test_black();
        logic [7:0] seq [6] = '{8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            frame(seq[i]);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL black[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
            if (i == 2) begin
                total++;
                if (drop_col_black !== 7'b1000000 || turn_red !== 1'b1 || move_count !== 6'd2)
                    $display("FAIL black_drop: got blk %b turn %b cnt %0d want 1000000 1 2", drop_col_black, turn_red, move_count);
                else passed++;
            end
        end
    endtask

    task automatic test_col_full();
        logic [7:0] seq [5] = '{8'h1E, 8'h1E, 8'h00, 8'h00, 8'h00};
        col_full = 7'b0000001;
        for (int i = 0; i < 5; i++) begin
            frame(seq[i]);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL col_full[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
            if (i == 0) begin
                total++;
                if (invalid !== 1'b1 || drop_col_red !== 7'd0 || move_count !== 6'd2)
                    $display("FAIL col_full_invalid: got inv %b red %b cnt %0d want 1 0 2", invalid, drop_col_red, move_count);
                else passed++;
            end
        end
        col_full = '0;
    endtask

    task automatic test_off_turn();
        logic [7:0] seq [3] = '{8'h14, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            frame(seq[i]);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL off_turn[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
        end
    endtask

    task automatic test_release_short();
        logic [7:0] seq [8] = '{8'h00, 8'h1F, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h04};
        for (int i = 0; i < 8; i++) begin
            frame(seq[i]);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL release[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
        end
    endtask

    task automatic test_back_unrec();
        logic [7:0] seq [5] = '{8'h04, 8'h05, 8'h00, 8'h00, 8'h05};
        for (int i = 0; i < 5; i++) begin
            frame(seq[i]);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL back[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
        end
        frame(8'h00); void'(exp_q.pop_front());
        frame(8'h00); void'(exp_q.pop_front());
    endtask

    task automatic test_full_board();
        logic [7:0] k;
        test_reset();
        for (int i = 0; i < 43; i++) begin
            k = (i % 2 == 0) ? 8'h1E + 8'((i / 2) % 7) : blk_keys[(i / 2) % 7];
            frame(k);
            exp_v = exp_q.pop_front();
            total++;
            if (dut_vec !== exp_v) $display("FAIL full_board[%0d]: got %h want %h", i, dut_vec, exp_v);
            else passed++;
            frame(8'h00); void'(exp_q.pop_front());
            frame(8'h00); void'(exp_q.pop_front());
        end
        total++;
        if (board_full !== 1'b1 || move_count !== 6'd42) $display("FAIL full_board_end: got full %b cnt %0d want 1 42", board_full, move_count);
        else passed++;
    endtask

    task automatic test_async_reset();
        frame(8'h21);
        exp_v = exp_q.pop_front();
        total++;
        if (dut_vec !== exp_v) $display("FAIL pre_reset: got %h want %h", dut_vec, exp_v);
        else passed++;
        keycode = 8'h1E;
        #2 Reset = 1;
        model_reset();
        #1;
        total++;
        if (dut_vec !== RESET_VEC) $display("FAIL async_reset: got %h want %h", dut_vec, RESET_VEC);
        else passed++;
        @(posedge frame_clk); #1;
        total++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_held: got %h want %h", dut_vec, RESET_VEC);
        else passed++;
        #1 Reset = 0;
        frame(8'h1E);
        exp_v = exp_q.pop_front();
        total++;
        if (dut_vec !== exp_v || drop_col_red !== 7'b0000001) $display("FAIL key_through_reset: got %h want %h", dut_vec, exp_v);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_black();
        test_col_full();
        test_off_turn();
        test_release_short();
        test_back_unrec();
        test_full_board();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
